// File: rtl/phase_accumulator.sv
// phase_accumulator: MIDI note -> 16-bit phase increment NCO front end.
// Accepts a note over a valid/ready handshake, looks up the equal-tempered
// increment, glides the live increment toward it and integrates it on ce.
module phase_accumulator #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [6:0]       note,
    input  logic             retrig,
    input  logic [3:0]       glide,
    output logic [6:0]       phase_out,
    output logic             wrap,
    output logic [ACC_W-1:0] inc_out
);

    typedef enum logic {IDLE = 1'b0, LOOKUP = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [6:0]       note_q, note_d;
    logic             retrig_q, retrig_d;
    logic [ACC_W-1:0] target_q, target_d;
    logic [ACC_W-1:0] cur_inc_q, cur_inc_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic             pend_q, pend_d;

    // Octave-0 increments for the twelve semitones, round(32768*2^(s/12)).
    function automatic logic [ACC_W-1:0] base_lut(input logic [6:0] s);
        case (s)
            7'd0:    base_lut = 16'd32768;
            7'd1:    base_lut = 16'd34716;
            7'd2:    base_lut = 16'd36781;
            7'd3:    base_lut = 16'd38968;
            7'd4:    base_lut = 16'd41285;
            7'd5:    base_lut = 16'd43740;
            7'd6:    base_lut = 16'd46341;
            7'd7:    base_lut = 16'd49097;
            7'd8:    base_lut = 16'd52016;
            7'd9:    base_lut = 16'd55109;
            7'd10:   base_lut = 16'd58386;
            default: base_lut = 16'd61858;
        endcase
    endfunction

    // Note decomposition and table shift; divide by a constant stays combinational.
    logic [6:0]       oct_w, semi_w;
    logic [3:0]       shamt_w;
    logic [ACC_W-1:0] lut_inc_w;
    assign oct_w     = note_q / 7'd12;
    assign semi_w    = note_q % 7'd12;
    assign shamt_w   = 4'd10 - oct_w[3:0];
    assign lut_inc_w = base_lut(semi_w) >> shamt_w;

    // Handshake FSM: IDLE accepts a note, LOOKUP registers its target increment.
    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        retrig_d   = retrig_q;
        target_d   = target_q;
        note_ready = 1'b0;
        case (state_q)
            IDLE: begin
                note_ready = 1'b1;
                if (note_valid) begin
                    note_d   = note;
                    retrig_d = retrig;
                    state_d  = LOOKUP;
                end
            end
            default: begin
                target_d = lut_inc_w;
                state_d  = IDLE;
            end
        endcase
    end

    // Glide, accumulate and retrigger for one sample (applied only when ce).
    // The add uses the increment produced by this same sample's glide step, so
    // a freshly reached pitch is integrated immediately; a target written on
    // this edge is not seen until the next ce. wrap is a one-clk pulse and is
    // dropped on non-ce cycles so oscillator sync sees a single edge.
    logic signed [ACC_W:0] diff_w, step_w, inc_sum_w;
    logic [ACC_W:0]        acc_sum_w;
    always_comb begin
        diff_w    = $signed({1'b0, target_q}) - $signed({1'b0, cur_inc_q});
        step_w    = diff_w >>> glide;
        if (step_w == '0 && diff_w != '0)
            step_w = diff_w[ACC_W] ? -17'sd1 : 17'sd1;
        inc_sum_w = $signed({1'b0, cur_inc_q}) + step_w;
        cur_inc_d = cur_inc_q;
        acc_d     = acc_q;
        wrap_d    = 1'b0;
        acc_sum_w = '0;
        if (ce) begin
            cur_inc_d = (glide == 4'd0) ? target_q : inc_sum_w[ACC_W-1:0];
            acc_sum_w = {1'b0, acc_q} + {1'b0, cur_inc_d};
            if (pend_q) begin
                acc_d = '0;
            end else begin
                acc_d  = acc_sum_w[ACC_W-1:0];
                wrap_d = acc_sum_w[ACC_W];
            end
        end
        // A retrigger latched this cycle survives a simultaneous ce.
        if (state_q == LOOKUP && retrig_q)
            pend_d = 1'b1;
        else if (ce)
            pend_d = 1'b0;
        else
            pend_d = pend_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            note_q    <= '0;
            retrig_q  <= 1'b0;
            target_q  <= '0;
            cur_inc_q <= '0;
            acc_q     <= '0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            retrig_q  <= retrig_d;
            target_q  <= target_d;
            cur_inc_q <= cur_inc_d;
            acc_q     <= acc_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
        end
    end

    assign phase_out = acc_q[ACC_W-1 -: 7];
    assign wrap      = wrap_q;
    assign inc_out   = cur_inc_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Bench for phase_accumulator: directed steps plus random notes against a
// pitch/phase reference built from the note arithmetic.
module tb_phase_accumulator;

    logic        clk = 0, rst = 1, ce = 0, note_valid = 0, retrig = 0;
    logic [6:0]  note = 0;
    logic [3:0]  glide = 0;
    logic        note_ready, wrap;
    logic [6:0]  phase_out;
    logic [15:0] inc_out;

    int checks = 0, errors = 0;
    int m_acc = 0, m_inc = 0, m_tgt = 0, m_wrap = 0;
    bit m_pend = 0;

    localparam int BASE [12] = '{32768, 34716, 36781, 38968, 41285, 43740,
                                 46341, 49097, 52016, 55109, 58386, 61858};

    phase_accumulator #(.ACC_W(16)) dut (
        .clk(clk), .rst(rst), .ce(ce), .note_valid(note_valid),
        .note_ready(note_ready), .note(note), .retrig(retrig), .glide(glide),
        .phase_out(phase_out), .wrap(wrap), .inc_out(inc_out)
    );

    always #5 clk = ~clk;

    function automatic int ref_target(int n);
        return BASE[n % 12] >> (10 - n / 12);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample of the reference: glide the pitch, then integrate it.
    task automatic model_ce();
        int d, st, s;
        d = m_tgt - m_inc;
        if (glide == 0) m_inc = m_tgt;
        else begin
            st = d >>> glide;
            if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
            m_inc = m_inc + st;
        end
        if (m_pend) begin
            m_acc = 0; m_wrap = 0; m_pend = 0;
        end else begin
            s = m_acc + m_inc;
            m_wrap = (s > 65535) ? 1 : 0;
            m_acc = s % 65536;
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, "_inc"}, 32'(inc_out), 32'(m_inc));
        chk({tag, "_phase"}, 32'(phase_out), 32'(m_acc >> 9));
        chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    // One ce pulse, compare, then confirm wrap has already dropped.
    task automatic do_ce(string tag);
        ce = 1;
        @(negedge clk);
        ce = 0;
        model_ce();
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_wrap_pulse"}, 32'(wrap), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!note_ready && n < 10) begin @(negedge clk); n++; end
        if (!note_ready) chk("ready_timeout", 32'(note_ready), 1);
    endtask

    task automatic load(int n, bit r);
        wait_ready();
        note_valid = 1; note = 7'(n); retrig = r;
        @(negedge clk);
        note_valid = 0;
        chk("lookup_ready", 32'(note_ready), 0);
        @(negedge clk);
        chk("idle_ready", 32'(note_ready), 1);
        m_tgt = ref_target(n);
        if (r) m_pend = 1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; #1;
        chk("rst_ready", 32'(note_ready), 1);
        chk("rst_phase", 32'(phase_out), 0);
        chk("rst_inc", 32'(inc_out), 0);
        chk("rst_wrap", 32'(wrap), 0);
        @(negedge clk); rst = 0;
        m_acc = 0; m_inc = 0; m_tgt = 0; m_wrap = 0; m_pend = 0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("init_ready", 32'(note_ready), 1);
        chk("init_phase", 32'(phase_out), 0);
        chk("init_inc", 32'(inc_out), 0);
        chk("init_wrap", 32'(wrap), 0);
        @(negedge clk); rst = 0;

        // Middle C, instant pitch: 4 samples
        glide = 0;
        load(60, 0);
        chk("tgt60", 32'(m_tgt), 1024);
        for (int i = 0; i < 4; i++) do_ce("n60");
        chk("n60_acc", 32'(phase_out), 8);

        // Table values
        load(69, 0); do_ce("n69"); chk("inc69", 32'(inc_out), 1722);
        load(127, 0); do_ce("n127"); chk("inc127", 32'(inc_out), 49097);
        load(0, 0); do_ce("n0"); chk("inc0", 32'(inc_out), 32);

        // Carry on the second add of note 127
        do_reset();
        load(127, 0);
        do_ce("w1");
        chk("w1_nowrap", 32'(wrap), 0);
        ce = 1; @(negedge clk); ce = 0; model_ce();
        chk("w2_wrap", 32'(wrap), 1);
        chk("w2_phase", 32'(phase_out), 32658 >> 9);
        @(negedge clk);
        chk("w2_onewide", 32'(wrap), 0);

        // Glide 1024 -> 2048 at rate 2
        do_reset();
        load(60, 0); do_ce("g0");
        glide = 2;
        load(72, 0);
        do_ce("g1"); chk("g1_step", 32'(inc_out), 1280);
        do_ce("g2"); chk("g2_step", 32'(inc_out), 1472);
        do_ce("g3"); chk("g3_step", 32'(inc_out), 1616);
        for (int i = 0; i < 40; i++) begin
            do_ce("gl");
            if (inc_out > 16'd2048) chk("glide_overshoot", 32'(inc_out), 2048);
        end
        chk("glide_final", 32'(inc_out), 2048);

        // Glide downward back to 1024
        glide = 3;
        load(60, 0);
        for (int i = 0; i < 50; i++) do_ce("gd");
        chk("glide_down_final", 32'(inc_out), 1024);
        glide = 0;

        // Retrigger clears a nonzero phase; no retrig continues
        for (int i = 0; i < 5; i++) do_ce("pre_rt");
        load(60, 1);
        do_ce("rt");
        chk("rt_zero", 32'(phase_out), 0);
        load(60, 0);
        do_ce("nort");

        // ce in the same clk as the target write (with retrig)
        wait_ready();
        note_valid = 1; note = 7'd72; retrig = 1;
        @(negedge clk);
        note_valid = 0; ce = 1;
        @(negedge clk);
        ce = 0;
        model_ce();
        m_tgt = ref_target(72); m_pend = 1;
        check_outputs("simul");
        do_ce("simul_next");
        chk("simul_cleared", 32'(phase_out), 0);

        // Back-to-back handshake
        wait_ready();
        note_valid = 1; note = 7'd48; retrig = 0;
        @(negedge clk);
        chk("b2b_low", 32'(note_ready), 0);
        note = 7'd84;
        @(negedge clk);
        chk("b2b_high", 32'(note_ready), 1);
        @(negedge clk);
        note_valid = 0;
        chk("b2b_low2", 32'(note_ready), 0);
        @(negedge clk);
        m_tgt = ref_target(84);
        do_ce("b2b");

        // Reset during LOOKUP discards the note
        wait_ready();
        note_valid = 1; note = 7'd100;
        @(negedge clk);
        note_valid = 0;
        do_reset();
        do_ce("post_rst");

        // Random notes, glide rates, retriggers and sample counts
        for (int k = 0; k < 25; k++) begin
            int nce;
            glide = 4'($urandom_range(0, 4));
            load(int'($urandom_range(0, 127)), bit'($urandom_range(0, 1)));
            nce = int'($urandom_range(1, 6));
            for (int j = 0; j < nce; j++) do_ce("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_accumulator.md
# phase_accumulator

Upstream NCO stage that converts a 7-bit MIDI note number into a 16-bit phase increment and integrates it at sample rate. Its top 7 bits drive the wave-mirroring sample lookup stage. It provides a valid/ready note-load handshake, optional exponential portamento toward the new pitch, phase retrigger, and a per-cycle wrap pulse for oscillator sync.

## Interface
Parameters:
- ACC_W, 16, accumulator and increment width; fixed at 16 for this table.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  sample-rate enable, one clk wide
- note_valid  in  1  note load request
- note_ready  out  1  block can accept a note this cycle
- note  in  7  MIDI note, 0..127
- retrig  in  1  sampled with note; clear phase when the target loads
- glide  in  4  portamento rate shift; 0 = instant
- phase_out  out  7  acc[15:9]
- wrap  out  1  one-clk pulse on accumulator carry-out
- inc_out  out  16  current increment (debug/modulation tap)

## Operation
- Note decomposition:
  - oct = note / 12 (0..10); semi = note % 12.
  - Divider is combinational, or shift-subtract with no extra latency beyond LOOKUP.
- BASE[semi] = round(32768·2^(semi/12)):
  - 32768, 34716, 36781, 38968, 41285, 43740, 46341, 49097, 52016, 55109, 58386, 61858.
- Target increment: target_inc = BASE[semi] >> (10 − oct). This is a 16-bit logical shift with truncation.
- FSM:
  - IDLE: note_ready=1. On note_valid, latch note and retrig, then go to LOOKUP.
  - LOOKUP: note_ready=0. Register target_inc from the table. If retrig was latched, pend_clear=1. Next state is IDLE.
- Accumulator, on each ce: acc <= acc + cur_inc, mod 2^16. wrap <= carry-out of that add.
- Glide, on each ce:
  - d = target_inc − cur_inc (17-bit signed).
  - If glide=0: cur_inc <= target_inc.
  - Else step = d >>> glide (arithmetic). If step=0 and d≠0, step = sign(d)·1.
  - cur_inc <= cur_inc + step. cur_inc never overshoots target_inc.
- Retrigger: pend_clear forces acc <= 0 on the next ce instead of accumulating, then pend_clear clears. wrap=0 on that ce.
- inc_out = cur_inc.
- Reset values: acc=0, cur_inc=0, target_inc=0, state IDLE, note_ready=1, wrap=0, pend_clear=0. phase_out=0.

## Timing
- Handshake: a transfer occurs when note_valid && note_ready at a clk edge. note_ready deasserts for exactly one clk (LOOKUP). Max throughput is one note per 2 clk.
- target_inc is valid 2 clk after the accepted edge. It first affects cur_inc at the first ce strictly after that.
- phase_out and wrap update one clk after the ce edge. wrap is high for exactly one clk.
- Simultaneous events:
  - ce in the same clk that target_inc is written: the glide step uses the old target, and the accumulator uses the old cur_inc.
  - ce in the same clk that pend_clear is set: the clear happens on the following ce.
- Glide=0 reaches the target in 1 ce. Nonzero glide converges monotonically and ends exactly on target.
- Reset mid-operation (any state, mid-glide) returns everything to reset values asynchronously. A note in LOOKUP is discarded.
- No ce: acc, cur_inc and wrap hold. The FSM still runs on clk.

## Test plan
- Reset, then note=60, glide=0, then 4 ce → target_inc=1024; inc_out=1024 after the first ce; acc=4096 after 4 ce; phase_out=8.
- Note=69 and note=127, glide=0 → inc_out=1722 and 49097. Note=0 → 32768>>10 = 32.
- Note=127, then 2 ce → wrap pulses on carry of the second add (acc=98194 mod 65536 = 32658). wrap is one clk wide.
- cur_inc=1024, then note=72 (target 2048), glide=2 → steps 256, 192, 144, … with final +1 steps. cur_inc reaches exactly 2048 and never exceeds it.
- retrig=1 with acc≠0 → acc=0 after the next ce. Without retrig, acc continues unchanged.
- Back-to-back note_valid → note_ready low 1 clk, second note accepted 2 clk after the first. Assert rst during LOOKUP → all outputs 0, note_ready=1.
